// File: rtl/hemaia_clock_freq_meter.sv
// Measures meas_clk_i against clk_i: counts meas edges over an N-cycle reference window and
// checks the count against expected_i +/- tolerance_i.
`timescale 1ns/1ps
module hemaia_clock_freq_meter #(
  parameter int unsigned CntWidth    = 16,
  parameter int unsigned WindowWidth = 16,
  parameter int unsigned SyncStages  = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   meas_clk_i,
  input  logic                   start_i,
  input  logic [WindowWidth-1:0] window_i,
  input  logic [CntWidth-1:0]    expected_i,
  input  logic [CntWidth-1:0]    tolerance_i,
  output logic                   busy_o,
  output logic                   done_o,
  output logic [CntWidth-1:0]    count_o,
  output logic                   pass_o
);

  typedef enum logic [1:0] {StIdle, StSnap, StMeas} state_e;

  // Meas domain: binary counter plus registered Gray copy; only the Gray register crosses.
  logic [CntWidth-1:0] meas_bin_q, meas_bin_d, meas_gray_q;

  assign meas_bin_d = meas_bin_q + CntWidth'(1);

  always_ff @(posedge meas_clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meas_bin_q  <= '0;
      meas_gray_q <= '0;
    end else begin
      meas_bin_q  <= meas_bin_d;
      meas_gray_q <= meas_bin_d ^ (meas_bin_d >> 1);
    end
  end

  logic [SyncStages-1:0][CntWidth-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= meas_gray_q;
      for (int i = 1; i < SyncStages; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  logic [CntWidth-1:0] snap_val;

  always_comb begin
    snap_val = '0;
    for (int i = 0; i < CntWidth; i++) begin
      snap_val[i] = ^(sync_q[SyncStages-1] >> i);
    end
  end

  state_e                 state_q, state_d;
  logic [WindowWidth-1:0] window_q, window_d;
  logic [WindowWidth-1:0] win_cnt_q, win_cnt_d;
  logic [CntWidth-1:0]    expected_q, expected_d;
  logic [CntWidth-1:0]    tolerance_q, tolerance_d;
  logic [CntWidth-1:0]    start_snap_q, start_snap_d;
  logic [CntWidth-1:0]    count_q, count_d;
  logic                   pass_q, pass_d;
  logic                   done_q, done_d;
  logic [CntWidth-1:0]    meas_diff, meas_err;

  // Modular subtraction absorbs a counter wrap between the two snapshots.
  assign meas_diff = snap_val - start_snap_q;
  assign meas_err  = (meas_diff >= expected_q) ? (meas_diff - expected_q)
                                               : (expected_q - meas_diff);

  always_comb begin
    state_d      = state_q;
    window_d     = window_q;
    win_cnt_d    = win_cnt_q;
    expected_d   = expected_q;
    tolerance_d  = tolerance_q;
    start_snap_d = start_snap_q;
    count_d      = count_q;
    pass_d       = pass_q;
    done_d       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start_i && (window_i != '0)) begin
          window_d    = window_i;
          expected_d  = expected_i;
          tolerance_d = tolerance_i;
          state_d     = StSnap;
        end
      end
      StSnap: begin
        start_snap_d = snap_val;
        win_cnt_d    = window_q;
        state_d      = StMeas;
      end
      StMeas: begin
        win_cnt_d = win_cnt_q - WindowWidth'(1);
        if (win_cnt_q == WindowWidth'(1)) begin
          count_d = meas_diff;
          pass_d  = (meas_err <= tolerance_q);
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      window_q     <= '0;
      win_cnt_q    <= '0;
      expected_q   <= '0;
      tolerance_q  <= '0;
      start_snap_q <= '0;
      count_q      <= '0;
      pass_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      window_q     <= window_d;
      win_cnt_q    <= win_cnt_d;
      expected_q   <= expected_d;
      tolerance_q  <= tolerance_d;
      start_snap_q <= start_snap_d;
      count_q      <= count_d;
      pass_q       <= pass_d;
      done_q       <= done_d;
    end
  end

  assign busy_o  = (state_q != StIdle);
  assign done_o  = done_q;
  assign count_o = count_q;
  assign pass_o  = pass_q;

endmodule

// File: tb/tb_hemaia_clock_freq_meter.sv
// Bench for hemaia_clock_freq_meter: directed and randomized windows checked against an
// edge-counting reference model of the measured clock.
`timescale 1ns/1ps
module tb_hemaia_clock_freq_meter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        meas_clk = 1'b0;
  realtime     meas_half = 0.0;

  logic        start = 1'b0, start8 = 1'b0;
  logic [15:0] window = '0, window8 = '0;
  logic [15:0] expected = '0, tolerance = '0;
  logic [7:0]  expected8 = '0, tolerance8 = '0;
  logic        busy, done, pass, busy8, done8, pass8;
  logic [15:0] count;
  logic [7:0]  count8;

  int tests = 0;
  int fails = 0;
  int unsigned edges = 0;
  int done_cnt = 0;

  hemaia_clock_freq_meter #(.CntWidth(16), .WindowWidth(16), .SyncStages(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .meas_clk_i(meas_clk), .start_i(start), .window_i(window),
    .expected_i(expected), .tolerance_i(tolerance), .busy_o(busy), .done_o(done),
    .count_o(count), .pass_o(pass)
  );

  hemaia_clock_freq_meter #(.CntWidth(8), .WindowWidth(16), .SyncStages(2)) u_dut8 (
    .clk_i(clk), .rst_ni(rst_n), .meas_clk_i(meas_clk), .start_i(start8), .window_i(window8),
    .expected_i(expected8), .tolerance_i(tolerance8), .busy_o(busy8), .done_o(done8),
    .count_o(count8), .pass_o(pass8)
  );

  always #5 clk = ~clk;

  // Meas edges stay on a .3/.8 ns grid so they never coincide with clk edges.
  initial begin
    #0.3;
    forever begin
      if (meas_half == 0.0) begin
        meas_clk = 1'b0;
        #0.5;
      end else begin
        #(meas_half);
        meas_clk = ~meas_clk;
      end
    end
  end

  // Reference model: rising edges of the measured clock since reset.
  always @(posedge meas_clk or negedge rst_n) begin
    if (!rst_n) edges <= 0;
    else        edges <= edges + 1;
  end

  always @(negedge clk) if (done) done_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int ref_v, input int slack);
    int dlt;
    tests++;
    dlt = obs - ref_v;
    if (dlt < 0) dlt = -dlt;
    assert (dlt <= slack) else begin
      fails++;
      $error("FAIL %s: observed %0d, expected %0d +/- %0d", tag, obs, ref_v, slack);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 one cycle after done.
  // pmode: 0 expect fail, 1 expect pass, 2 pass not determinable.
  task automatic measure(input string tag, input int n, input int exp_v, input int tol_v,
                         input int pmode);
    int unsigned e0, e1;
    window = 16'(n); expected = 16'(exp_v); tolerance = 16'(tol_v); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    window = 16'($urandom); expected = 16'($urandom); tolerance = 16'($urandom);
    check({tag, " busy_c1"}, busy, 1);
    @(posedge clk); e0 = edges;
    repeat (n - 1) @(posedge clk);
    #1;
    check({tag, " done_early"}, done, 0);
    check({tag, " busy_cN1"}, busy, 1);
    @(posedge clk); e1 = edges;
    #1;
    check({tag, " done"}, done, 1);
    check({tag, " busy_low"}, busy, 0);
    check_near({tag, " count"}, int'(count), int'((e1 - e0) & 32'hffff), 1);
    if (pmode != 2) check({tag, " pass"}, pass, pmode);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, done, 0);
  endtask

  initial begin
    int unsigned e0, e1;
    int dc, h2, n, ir, d, ad, tol, ex, pm;
    bit found;
    real ideal;

    repeat (3) @(posedge clk);
    #1;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst count", count, 0);
    check("rst pass", pass, 0);
    check("rst count8", count8, 0);
    rst_n = 1'b1;

    // Divide-by-4 reference: 400 cycles of 10 ns over a 40 ns period is 100 edges.
    meas_half = 20.0;
    repeat (10) @(posedge clk);
    #1;
    measure("div4", 400, 100, 1, 1);
    check_near("div4 ideal", int'(count), 100, 1);

    // Stopped clock.
    meas_half = 0.0;
    repeat (10) @(posedge clk);
    #1;
    measure("stopped", 50, 10, 2, 0);
    check("stopped count", count, 0);

    // Measured clock faster than the reference.
    meas_half = 1.5;
    repeat (10) @(posedge clk);
    #1;
    measure("fast", 300, 1000, 1, 1);
    check_near("fast ideal", int'(count), 1000, 1);

    // Randomized periods, windows, expectations and tolerances.
    for (int it = 0; it < 5; it++) begin
      h2 = $urandom_range(3, 40);
      n = $urandom_range(20, 150);
      ideal = n * 10.0 / h2;
      ir = $rtoi(ideal + 0.5);
      d = $urandom_range(0, 16) - 8;
      tol = $urandom_range(0, 6);
      ex = ir + d;
      if (ex < 0) ex = 0;
      ad = ex - ir;
      if (ad < 0) ad = -ad;
      pm = (ad + 3 <= tol) ? 1 : ((ad - 3 > tol) ? 0 : 2);
      meas_half = h2 * 0.5;
      repeat (10) @(posedge clk);
      #1;
      measure("rand", n, ex, tol, pm);
      check_near("rand ideal", int'(count), ir, 2);
    end

    // 8-bit counter wraps inside the window.
    meas_half = 10.0;
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      @(posedge clk);
      if ((edges % 256) >= 236 && (edges % 256) <= 240) found = 1'b1;
    end
    #1;
    check("wrap reach", found, 1);
    window8 = 16'd40; expected8 = 8'd20; tolerance8 = 8'd1; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    @(posedge clk); e0 = edges;
    repeat (39) @(posedge clk);
    @(posedge clk); e1 = edges;
    #1;
    check("wrap done8", done8, 1);
    check_near("wrap count8", int'(count8), 20, 1);
    check_near("wrap model8", int'(count8), int'((e1 - e0) & 32'hff), 1);
    check("wrap pass8", pass8, 1);

    // start_i during busy is ignored.
    dc = done_cnt;
    window = 16'd30; expected = 16'd15; tolerance = 16'd2; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    window = 16'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (26) @(posedge clk);
    #1;
    check("busy_start done", done, 1);
    check("busy_start pass", pass, 1);
    repeat (12) @(posedge clk);
    #1;
    check("busy_start single", done_cnt - dc, 1);

    // window_i == 0 is ignored.
    dc = done_cnt;
    window = 16'd0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("win0 busy", busy, 0);
    repeat (4) @(posedge clk);
    #1;
    check("win0 busy_late", busy, 0);
    check("win0 no_done", done_cnt - dc, 0);

    // Back-to-back: restart in the done cycle.
    window = 16'd8; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    check("b2b done_early", done, 0);
    @(posedge clk); #1;
    check("b2b done1", done, 1);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b busy", busy, 1);
    repeat (8) @(posedge clk);
    #1;
    check("b2b done2_early", done, 0);
    @(posedge clk); #1;
    check("b2b done2", done, 1);

    // Reset mid-measurement aborts the window with no done.
    @(posedge clk); #1;
    window = 16'd100; expected = 16'd50; tolerance = 16'd1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (19) @(posedge clk);
    #1;
    check("abort busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    dc = done_cnt;
    check("abort busy", busy, 0);
    check("abort count", count, 0);
    check("abort pass", pass, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    check("abort no_done", done_cnt - dc, 0);
    check("abort idle", busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
